// File: rtl/alu_pkg.sv
// Shared constants for ALU16 and the multiply/divide sequencer.
package alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;
endpackage

// File: rtl/alu16.sv
// Shared execute-stage ALU; op[2] inverts B and injects carry-in.
module ALU16
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             co
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  assign b_eff = op[2] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[2]};
  assign co    = sum[WIDTH];
  assign ovf   = (a[WIDTH-1] ~^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);

  always_comb begin
    r = '0;
    case (op)
      ALU_AND: r = a & b_eff;
      ALU_OR:  r = a | b_eff;
      ALU_ADD,
      ALU_SUB: r = sum[WIDTH-1:0];
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: r = sum[WIDTH-1:0];
    endcase
  end
endmodule

// File: rtl/muldiv_step.sv
// One shift-add / restoring-divide iteration: next {HI,LO} from the ALU result.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] alu_r_i,
  input  logic             alu_co_i,
  output logic [WIDTH-1:0] div_a_o,
  output logic [WIDTH-1:0] hi_d_o,
  output logic [WIDTH-1:0] lo_d_o
);
  // Shifted partial remainder; bit WIDTH set means S >= 2^WIDTH > divisor.
  logic [WIDTH:0] s;

  assign s       = {hi_i, lo_i[WIDTH-1]};
  assign div_a_o = s[WIDTH-1:0];

  always_comb begin
    hi_d_o = hi_i;
    lo_d_o = lo_i;
    if (mode_i == MODE_MUL) begin
      if (lo_i[0]) {hi_d_o, lo_d_o} = {alu_co_i, alu_r_i, lo_i[WIDTH-1:1]};
      else         {hi_d_o, lo_d_o} = {1'b0, hi_i, lo_i[WIDTH-1:1]};
    end else begin
      if (s[WIDTH] | alu_co_i) begin
        hi_d_o = alu_r_i;
        lo_d_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_d_o = s[WIDTH-1:0];
        lo_d_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned mul/div sequencer that borrows ALU16 one pass per clock.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] m_q, hi_q, lo_q;
  logic [WIDTH-1:0] hi_d, lo_d, div_a;
  logic             mode_q, div0_q;
  logic             div_by_zero;

  assign div_by_zero = (mode_q == MODE_DIV) && (m_q == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i  (mode_q),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .alu_r_i (alu_r),
    .alu_co_i(alu_co),
    .div_a_o (div_a),
    .hi_d_o  (hi_d),
    .lo_d_o  (lo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = div_by_zero ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU bus stays quiet (AND of zeros) whenever no iteration is running.
  always_comb begin
    alu_op = ALU_AND;
    alu_a  = '0;
    alu_b  = '0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      S_LOAD: busy = 1'b1;
      S_RUN: begin
        busy   = 1'b1;
        alu_op = (mode_q == MODE_DIV) ? ALU_SUB : ALU_ADD;
        alu_a  = (mode_q == MODE_DIV) ? div_a : hi_q;
        alu_b  = m_q;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured on the edge that enters LOAD, so opa/opb only
  // need to be valid alongside start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_MUL;
      div0_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          mode_q <= mode;
          div0_q <= 1'b0;
          hi_q   <= '0;
          m_q    <= (mode == MODE_DIV) ? opb : opa;
          lo_q   <= (mode == MODE_DIV) ? opa : opb;
        end
        S_LOAD: begin
          cnt_q <= CNT_W'(WIDTH - 1);
          if (div_by_zero) begin
            div0_q <= 1'b1;
            hi_q   <= lo_q;
            lo_q   <= '1;
          end
        end
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign res_hi = hi_q;
  assign res_lo = lo_q;
  assign div0   = div0_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq paired with a real ALU16; scoreboard of expected results.
module tb_alu_muldiv_seq;
  import alu_pkg::*;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_r, res_hi, res_lo;
  logic         alu_co, busy, done, div0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .opa(opa), .opb(opb),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_co(alu_co),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div0(div0)
  );

  ALU16 #(.WIDTH(W)) u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .r(alu_r), .co(alu_co));

  // Drives one operation, pushes its expectation, and waits (bounded) for done.
  task automatic run_op(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, output int lat, output logic [W-1:0] hi,
                        output logic [W-1:0] lo, output logic dz, output bit busy_drop,
                        output bit nonand, output bit done_long);
    exp_t e;
    logic [31:0] p;
    if (md) begin
      e.dz  = (b == 0);
      e.hi  = (b == 0) ? a : a % b;
      e.lo  = (b == 0) ? 16'hFFFF : a / b;
      e.lat = (b == 0) ? 2 : 18;
    end else begin
      p     = 32'(a) * 32'(b);
      e.hi  = p[31:16];
      e.lo  = p[15:0];
      e.dz  = 1'b0;
      e.lat = 18;
    end
    sb.push_back(e);
    busy_drop = 0; nonand = 0; done_long = 0;
    @(negedge clk);
    start = 1'b1; mode = md; opa = a; opb = b;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0; mode = ~md; opa = 16'($urandom); opb = 16'($urandom);
    while (lat < 100) begin
      @(negedge clk);
      if (alu_op != ALU_AND) nonand = 1;
      if (done) break;
      if (!busy) busy_drop = 1;
      if (pulse_at != 0 && lat == pulse_at) begin
        start = 1'b1; mode = ~md; opa = 16'h00AA; opb = 16'h0003;
      end else start = 1'b0;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    hi = res_hi; lo = res_lo; dz = div0;
    @(posedge clk);
    #1 done_long = done;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, div0, res_hi, res_lo, alu_op, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b div0=%b hi=%h lo=%h op=%b a=%h b=%h required all zero",
               busy, done, div0, res_hi, res_lo, alu_op, alu_a, alu_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic         md_t[8] = '{0, 0, 0, 1, 1, 0, 1, 1};
    logic [W-1:0] a_t[8]  = '{16'd3, 16'hFFFF, 16'h1234, 16'd100, 16'hFFFF, 16'h0, 16'h1234, 16'h8000};
    logic [W-1:0] b_t[8]  = '{16'd5, 16'hFFFF, 16'hABCD, 16'd7, 16'h8001, 16'h7777, 16'h1235, 16'h0001};
    int lat; logic [W-1:0] hi, lo; logic dz; bit bd, na, dl;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      logic md; logic [W-1:0] a, b;
      if (i < 8) begin md = md_t[i]; a = a_t[i]; b = b_t[i]; end
      else begin md = i[0]; a = 16'($urandom); b = 16'($urandom_range(1, 16'hFFFF)); end
      run_op(md, a, b, 0, lat, hi, lo, dz, bd, na, dl);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL arith_latency md=%b a=%h b=%h got %0d exp %0d", md, a, b, lat, e.lat); end
      checks++;
      if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL arith_result md=%b a=%h b=%h got %h_%h exp %h_%h", md, a, b, hi, lo, e.hi, e.lo); end
      checks++;
      if (dz !== e.dz) begin errors++; $display("FAIL arith_div0 md=%b a=%h b=%h got %b exp %b", md, a, b, dz, e.dz); end
      checks++;
      if (bd || dl) begin errors++; $display("FAIL arith_handshake md=%b a=%h b=%h busy_drop=%b done_long=%b exp 0 0", md, a, b, bd, dl); end
    end
  endtask

  task automatic test_div0();
    int lat; logic [W-1:0] hi, lo; logic dz; bit bd, na, dl;
    exp_t e;
    run_op(1'b1, 16'h1234, 16'h0000, 0, lat, hi, lo, dz, bd, na, dl);
    e = sb.pop_front();
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL div0_latency got %0d exp 2", lat); end
    checks++;
    if ({dz, hi, lo} !== {e.dz, e.hi, e.lo}) begin errors++; $display("FAIL div0_result got dz=%b %h_%h exp dz=%b %h_%h", dz, hi, lo, e.dz, e.hi, e.lo); end
    checks++;
    if (na) begin errors++; $display("FAIL div0_quiet_bus got non-AND opcode exp ALU_AND throughout"); end
    checks++;
    if (div0 !== 1'b1) begin errors++; $display("FAIL div0_hold got %b exp 1", div0); end
    // The next operation must clear the flag.
    run_op(1'b1, 16'd9, 16'd2, 0, lat, hi, lo, dz, bd, na, dl);
    e = sb.pop_front();
    checks++;
    if ({dz, hi, lo} !== {e.dz, e.hi, e.lo}) begin errors++; $display("FAIL div0_clear got dz=%b %h_%h exp dz=%b %h_%h", dz, hi, lo, e.dz, e.hi, e.lo); end
  endtask

  task automatic test_start_ignored();
    int lat; logic [W-1:0] hi, lo; logic dz; bit bd, na, dl;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      run_op(k[0], 16'hBEEF, 16'h0123, 5 + 4 * k, lat, hi, lo, dz, bd, na, dl);
      e = sb.pop_front();
      checks++;
      if ({hi, lo, dz} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
        errors++;
        $display("FAIL start_ignored k=%0d got %h_%h dz=%b lat=%0d exp %h_%h dz=%b lat=%0d", k, hi, lo, dz, lat, e.hi, e.lo, e.dz, e.lat);
      end
      checks++;
      if (bd) begin errors++; $display("FAIL start_ignored_busy k=%0d busy dropped early exp held", k); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] hi, lo; logic dz; bit bd, na, dl;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      run_op(k == 1, 16'(40 + k), 16'(3 + k), 0, lat, hi, lo, dz, bd, na, dl);
      e = sb.pop_front();
      checks++;
      if ({hi, lo} !== {e.hi, e.lo} || lat !== e.lat) begin
        errors++;
        $display("FAIL back_to_back k=%0d got %h_%h lat=%0d exp %h_%h lat=%0d", k, hi, lo, lat, e.hi, e.lo, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [W-1:0] hi, lo; logic dz; bit bd, na, dl, saw_done;
    exp_t e;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; opa = 16'd7; opb = 16'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div0, res_hi, res_lo, alu_op, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async busy=%b done=%b div0=%b hi=%h lo=%h op=%b a=%h b=%h required all zero",
               busy, done, div0, res_hi, res_lo, alu_op, alu_a, alu_b);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL reset_mid_no_done got activity after reset exp idle"); end
    run_op(1'b0, 16'd2, 16'd2, 0, lat, hi, lo, dz, bd, na, dl);
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || lo !== 16'd4 || lat !== 18) begin
      errors++;
      $display("FAIL reset_mid_restart got %h_%h lat=%0d exp 0000_0004 lat=18", hi, lo, lat);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div0();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that performs unsigned 16x16 multiply and 16/16 divide using the shared 16-bit ALU (ALU16) through that ALU's op/a/b/r/co ports.
- Sits beside ALU16 in the execute stage: while busy it owns the ALU inputs; the core mux hands ALU control to this block whenever busy=1.
- Multiply is shift-add; divide is restoring; each algorithm makes one ALU pass per clock.

Parameters:
- WIDTH, 16, operand/ALU width; only 16 is verified.
- CNT_W, 5, iteration counter width, must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = multiply, 1 = divide; sampled with start
- opa  input  WIDTH  multiplicand / dividend; sampled with start
- opb  input  WIDTH  multiplier / divisor; sampled with start
- alu_op  output  3  ALU opcode driven to ALU16
- alu_a  output  WIDTH  ALU operand A
- alu_b  output  WIDTH  ALU operand B
- alu_r  input  WIDTH  ALU result (combinational from alu_op/a/b)
- alu_co  input  1  ALU carry-out of MSB; for SUB, 1 = no borrow
- busy  output  1  high in LOAD and RUN
- done  output  1  one-cycle pulse in DONE state
- res_hi  output  WIDTH  product[31:16] / remainder
- res_lo  output  WIDTH  product[15:0] / quotient
- div0  output  1  divide-by-zero flag, valid with done, held until next start

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, div0=0, res_hi=res_lo=0, counter=0, alu_op=ALU_AND, alu_a=alu_b=0. Release is synchronous to clk.
- ALU opcodes are fixed: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111. op[2] inverts B; ALU16 injects carry-in = op[2].
- FSM: IDLE -> LOAD on start=1. LOAD -> RUN normally; LOAD -> DONE if mode=1 and divisor==0. RUN -> DONE after WIDTH iterations (counter WIDTH-1 down to 0). DONE -> IDLE unconditionally.
- start outside IDLE is ignored. There is no abort; reset is the only way to cancel.
- LOAD: latch operands into internal M (opa for mul, opb for div), HI=0, LO (opb for mul, opa for div), counter=WIDTH-1. Clear div0.
- Multiply RUN cycle:
  - alu_op=ADD, alu_a=HI, alu_b=M.
  - If LO[0]=1: {HI,LO} <= {alu_co, alu_r, LO[15:1]}.
  - Else: {HI,LO} <= {1'b0, HI, LO[15:1]}.
- Divide RUN cycle:
  - Form shifted remainder S={HI,LO[15]} (17 bits).
  - Drive alu_op=SUB, alu_a=S[15:0], alu_b=M.
  - Accept when S[16]|alu_co: HI<=alu_r, LO<={LO[14:0],1}.
  - Otherwise: HI<=S[15:0], LO<={LO[14:0],0}.
- Outside RUN: alu_op=ALU_AND, alu_a=alu_b=0 (quiet bus).
- DONE: done=1 for exactly one cycle; res_hi/res_lo hold HI/LO and stay stable until the next LOAD.
- Divide by zero: LOAD sets div0=1, HI=opa, LO=16'hFFFF, then goes straight to DONE. Latency is 2 cycles from the start cycle to done.
- Latency, normal case: start sampled at edge 0; LOAD at edge 1; RUN over edges 2..17; done high in the cycle after edge 17 (18 cycles after start). Back-to-back: next start accepted in the cycle after done.
- Reset mid-operation: immediate return to reset values; partial results are discarded and done is not pulsed.
- Width rule: all arithmetic is performed by ALU16. The block itself only shifts and muxes, with no adder of its own.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ALU_AND/OR/ADD/SUB/SLT.
  - FSM state encoding S_IDLE=2'd0, S_LOAD=2'd1, S_RUN=2'd2, S_DONE=2'd3.
  - MODE_MUL=0, MODE_DIV=1.
- One sub-module is natural: muldiv_step, the combinational next-{HI,LO} logic for one iteration given mode, alu_r, alu_co. The FSM, counter and registers stay in the top level.
- Benches instantiate this block together with a real ALU16, not a model.

Test Plan:
- mul 3*5 -> done at cycle 18 after start, res_hi=0x0000, res_lo=0x000F, div0=0.
- mul 0xFFFF*0xFFFF -> res_hi=0xFFFE, res_lo=0x0001; checks the carry path through alu_co.
- div 100/7 -> res_lo=14, res_hi=2; div 0xFFFF/0x8001 -> res_lo=1, res_hi=0x7FFE; checks the S[16] accept path.
- div 0x1234/0 -> done 2 cycles after start, div0=1, res_lo=0xFFFF, res_hi=0x1234, alu_op stays ALU_AND throughout.
- start pulsed during RUN with different operands -> ignored; result matches the first operation; busy never drops early.
- rst_n low for 1 cycle at RUN iteration 8 -> all outputs at reset values asynchronously, no done pulse; a new start then completes correctly (mul 2*2 -> 4).
